// File: rtl/demod_spi_readout.sv
`default_nettype none
// ==========================================================================
// demod_spi_readout : packs demodulated bits into bytes, buffers them in a
//                     FIFO and serves them over an SPI slave, status first.
// Revision          : 1.0
// ==========================================================================
module demod_spi_readout #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       main_clk,
  input  logic       rst,
  input  logic       bit_i,
  input  logic       bit_valid_i,
  input  logic       sclk_i,
  input  logic       cs_i,
  output logic       sdo_o,
  output logic [5:0] fifo_level_o,
  output logic       overflow_o,
  output logic       frame_active_o
);

  localparam int                  c_ADDR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [5:0]          c_DEPTH   = 6'(FIFO_DEPTH);
  localparam logic [c_ADDR_W-1:0] c_PTR_ONE = c_ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATUS = 2'd1,
    ST_SHIFT  = 2'd2
  } state_t;

  // Bit packer
  logic [6:0] r_pack_sr;
  logic [2:0] r_pack_cnt;
  logic       r_push;
  logic [7:0] r_push_data;

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      r_pack_sr   <= '0;
      r_pack_cnt  <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= 1'b0;
      if (bit_valid_i) begin
        if (r_pack_cnt == 3'd7) begin
          r_push      <= 1'b1;
          r_push_data <= {r_pack_sr, bit_i};
          r_pack_cnt  <= '0;
        end else begin
          r_pack_sr  <= {r_pack_sr[5:0], bit_i};
          r_pack_cnt <= r_pack_cnt + 3'd1;
        end
      end
    end
  end

  // Synchronizers; cs resets to its idle (high) level so no false frame start
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_i};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  assign w_sclk_rise =  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] &  r_sclk_prev;
  assign w_cs_rise   =  r_cs_sync[SYNC_STAGES-1]   & ~r_cs_prev;
  assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-1]   &  r_cs_prev;

  // FIFO
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [5:0]          r_count;
  logic                r_ovf;
  logic                w_empty, w_full, w_pop, w_push_ok, w_drop;
  logic [7:0]          w_next_byte;
  logic [7:0]          w_status;

  assign w_empty     = (r_count == 6'd0);
  assign w_full      = (r_count == c_DEPTH);
  // Pop is applied first, so a push into a full FIFO that is popping is kept
  assign w_push_ok   = r_push & (~w_full | w_pop);
  assign w_drop      = r_push & w_full & ~w_pop;
  assign w_next_byte = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign w_status    = {r_ovf, 2'b00, r_count[4:0]};

  always_ff @(posedge main_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= r_push_data;
  end

  // FSM
  state_t     r_state, w_state_nxt;
  logic [7:0] r_shift;
  logic [3:0] r_bitcnt;
  logic       r_sdo;
  logic       w_load_status, w_shift, w_load_next, w_cnt_inc, w_clear_sdo;

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_status = 1'b0;
    w_shift       = 1'b0;
    w_load_next   = 1'b0;
    w_cnt_inc     = 1'b0;
    w_clear_sdo   = 1'b0;
    w_pop         = 1'b0;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
      w_clear_sdo = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) w_state_nxt = ST_STATUS;
        end
        ST_STATUS: begin
          w_load_status = 1'b1;
          w_state_nxt   = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_sclk_rise) w_cnt_inc = 1'b1;
          if (w_sclk_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_load_next = 1'b1;
              w_pop       = ~w_empty;
            end else begin
              w_shift = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_clear_sdo = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_sdo    <= 1'b0;
    end else begin
      if (w_clear_sdo) r_sdo <= 1'b0;
      if (w_load_status) begin
        r_shift  <= w_status;
        r_bitcnt <= '0;
        r_sdo    <= w_status[7];
      end
      if (w_shift) begin
        r_shift <= {r_shift[6:0], 1'b0};
        r_sdo   <= r_shift[6];
      end
      if (w_load_next) begin
        r_shift  <= w_next_byte;
        r_bitcnt <= '0;
        r_sdo    <= w_next_byte[7];
      end
      if (w_cnt_inc) r_bitcnt <= r_bitcnt + 4'd1;
    end
  end

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      r_count <= r_count + {5'd0, w_push_ok} - {5'd0, w_pop};
      // Reading the status clears the sticky flag unless a drop lands that cycle
      if (w_load_status) r_ovf <= w_drop;
      else if (w_drop)   r_ovf <= 1'b1;
    end
  end

  assign sdo_o          = r_sdo;
  assign fifo_level_o   = r_count;
  assign overflow_o     = r_ovf;
  assign frame_active_o = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_demod_spi_readout.sv
`default_nettype none
// Directed bench for demod_spi_readout with a queue-based model of the
// packer/FIFO/SPI readout and literal expectations at key points.
module tb_demod_spi_readout;

  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

  logic       main_clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_i = 1'b0, bit_valid_i = 1'b0;
  logic       sclk_i = 1'b0, cs_i = 1'b1;
  logic       sdo_o;
  logic [5:0] fifo_level_o;
  logic       overflow_o, frame_active_o;

  demod_spi_readout #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .main_clk(main_clk), .rst(rst), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .sclk_i(sclk_i), .cs_i(cs_i), .sdo_o(sdo_o), .fifo_level_o(fifo_level_o),
    .overflow_o(overflow_o), .frame_active_o(frame_active_o)
  );

  always #5 main_clk = ~main_clk;

  int n_vec = 0, n_err = 0;
  logic [7:0] q[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rx[$];
  logic m_ovf = 1'b0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rxb(input int k);
    return (rx.size() > k) ? rx[k] : 8'hxx;
  endfunction

  function automatic logic [7:0] m_status();
    int sz = q.size();
    return {m_ovf, 2'b00, sz[4:0]};
  endfunction

  // Steady-state checker between transactions
  always @(posedge main_clk) begin
    #1;
    if (chk_en) begin
      check("level", {2'b00, fifo_level_o}, 8'(q.size()));
      check("overflow", {7'd0, overflow_o}, {7'd0, m_ovf});
      check("frame_active_idle", {7'd0, frame_active_o}, 8'h00);
      check("sdo_idle", {7'd0, sdo_o}, 8'h00);
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge main_clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge main_clk);
    bit_i = b; bit_valid_i = 1'b1;
    @(negedge main_clk);
    bit_valid_i = 1'b0;
  endtask

  task automatic m_push(input logic [7:0] v);
    if (q.size() < DEPTH) q.push_back(v);
    else m_ovf = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    chk_en = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    m_push(v);
    cyc(3);
    chk_en = 1'b1;
    cyc(2);
  endtask

  // Model of one frame of nclk sclk periods: status, then a load at every 8th fall
  task automatic m_frame(input int nclk);
    exp_rd.delete();
    exp_rd.push_back(m_status());
    m_ovf = 1'b0;
    for (int k = 1; k <= nclk / 8; k++)
      exp_rd.push_back((q.size() > 0) ? q.pop_front() : 8'h00);
  endtask

  task automatic spi_frame(input int nclk);
    logic [7:0] cur;
    chk_en = 1'b0;
    m_frame(nclk);
    rx.delete();
    cur = 8'h00;
    cs_i = 1'b0;
    cyc(SYNC + 4);
    check("frame_active_busy", {7'd0, frame_active_o}, 8'h01);
    for (int i = 0; i < nclk; i++) begin
      cur = {cur[6:0], sdo_o};
      sclk_i = 1'b1;
      cyc(4);
      sclk_i = 1'b0;
      cyc(4);
      if ((i % 8) == 7) rx.push_back(cur);
    end
    cs_i = 1'b1;
    cyc(SYNC + 3);
    for (int k = 0; k < nclk / 8; k++) check("spi_byte", rxb(k), exp_rd[k]);
    chk_en = 1'b1;
    cyc(2);
  endtask

  initial begin
    logic [7:0] v5;
    logic [7:0] st5;
    logic [7:0] cur;

    cyc(3);
    check("rst_sdo", {7'd0, sdo_o}, 8'h00);
    check("rst_level", {2'b00, fifo_level_o}, 8'h00);
    check("rst_overflow", {7'd0, overflow_o}, 8'h00);
    check("rst_frame_active", {7'd0, frame_active_o}, 8'h00);
    rst = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    cyc(2);

    // 1: single byte 0xA5, read in a 16-clock frame
    send_byte(8'hA5);
    check("t1_level", {2'b00, fifo_level_o}, 8'h01);
    spi_frame(16);
    check("t1_status", rxb(0), 8'h01);
    check("t1_data", rxb(1), 8'hA5);
    check("t1_level_after", {2'b00, fifo_level_o}, 8'h00);

    // 2: empty FIFO reads zeros
    spi_frame(24);
    check("t2_b0", rxb(0), 8'h00);
    check("t2_b1", rxb(1), 8'h00);
    check("t2_b2", rxb(2), 8'h00);

    // 3: overfill by one
    for (int i = 0; i < 17; i++) send_byte(8'(i * 13 + 7));
    check("t3_level", {2'b00, fifo_level_o}, 8'h10);
    check("t3_overflow", {7'd0, overflow_o}, 8'h01);
    spi_frame(8);
    check("t3_status", rxb(0), 8'h90);
    check("t3_overflow_cleared", {7'd0, overflow_o}, 8'h00);
    check("t3_level_after", {2'b00, fifo_level_o}, 8'h0F);
    send_byte(8'h5A);

    // 5: full FIFO, packer push lands on the same cycle as a byte-boundary pop
    v5 = 8'h3C;
    chk_en = 1'b0;
    for (int i = 7; i >= 1; i--) send_bit(v5[i]);
    st5 = m_status();
    m_ovf = 1'b0;
    void'(q.pop_front());
    m_push(v5);
    cur = 8'h00;
    cs_i = 1'b0;
    cyc(SYNC + 4);
    for (int i = 0; i < 8; i++) begin
      cur = {cur[6:0], sdo_o};
      sclk_i = 1'b1;
      cyc(4);
      sclk_i = 1'b0;
      if (i == 7) begin
        cyc(SYNC - 1);
        bit_i = v5[0]; bit_valid_i = 1'b1;
        cyc(1);
        bit_valid_i = 1'b0;
        cyc(4);
      end else begin
        cyc(4);
      end
    end
    cs_i = 1'b1;
    cyc(SYNC + 3);
    check("t5_status_model", cur, st5);
    check("t5_status", cur, 8'h10);
    check("t5_level", {2'b00, fifo_level_o}, 8'h10);
    check("t5_overflow", {7'd0, overflow_o}, 8'h00);
    chk_en = 1'b1;
    cyc(2);

    // Drain to level 3 (13 loads, the last one lost at frame end)
    spi_frame(104);
    check("drain_level", {2'b00, fifo_level_o}, 8'h03);

    // 4: chip select raised mid byte after two loads
    spi_frame(20);
    check("t4_level", {2'b00, fifo_level_o}, 8'h01);
    check("t4_frame_active", {7'd0, frame_active_o}, 8'h00);
    check("t4_sdo", {7'd0, sdo_o}, 8'h00);

    // 6: reset mid-frame at level 5
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
    check("t6_level_before", {2'b00, fifo_level_o}, 8'h05);
    chk_en = 1'b0;
    cs_i = 1'b0;
    cyc(SYNC + 4);
    for (int i = 0; i < 5; i++) begin
      sclk_i = 1'b1; cyc(4);
      sclk_i = 1'b0; cyc(4);
    end
    sclk_i = 1'b1;
    cyc(2);
    rst = 1'b1;
    #1;
    check("t6_sdo", {7'd0, sdo_o}, 8'h00);
    check("t6_level", {2'b00, fifo_level_o}, 8'h00);
    check("t6_overflow", {7'd0, overflow_o}, 8'h00);
    check("t6_frame_active", {7'd0, frame_active_o}, 8'h00);
    q.delete();
    m_ovf = 1'b0;
    cs_i = 1'b1;
    sclk_i = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    spi_frame(8);
    check("t6_status_after", rxb(0), 8'h00);

    chk_en = 1'b0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
